// File: rtl/sersub_pkg.sv
// rtl/sersub_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Contents:
//   sersub_state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   SERSUB_WIDTH   : default operand/result width
package sersub_pkg;

  localparam int SERSUB_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sersub_state_t;

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// rtl/serial_subtractor_fullsub.sv - single-bit full-subtractor cell
//
// Purely combinational: d = a - b - bin (one bit), bout = borrow out.
// Ports:
//   a    : in  minuend bit
//   b    : in  subtrahend bit
//   bin  : in  borrow in
//   d    : out difference bit
//   bout : out borrow out
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, diff = a - b, LSB first
//
// One full-subtractor cell processes one bit per clock. Operands are taken
// on an in_valid/in_ready handshake, the result is offered on an
// out_valid/out_ready handshake; one operation is in flight at a time.
// Optional feature macro: SERSUB_OVF_EN adds the registered signed-overflow
// output ovf.
// Ports:
//   clk       : in  rising-edge clock
//   rst       : in  synchronous active-high reset
//   in_valid  : in  operands valid
//   in_ready  : out block can accept operands (IDLE only)
//   a, b      : in  minuend / subtrahend, WIDTH bits
//   out_valid : out result valid (DONE only)
//   out_ready : in  consumer accepts result
//   diff      : out a - b modulo 2^WIDTH
//   bout      : out final borrow (unsigned a < b)
//   ovf       : out signed overflow (SERSUB_OVF_EN only)
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = SERSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sersub_state_t    r_state;
  sersub_state_t    w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bnext;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_LAST);

  // The operand registers shift right, so bit 0 is always the current bit.
  fullsubtractor u_fullsub (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bnext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next_state = SHIFT;
      SHIFT:   if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shift registers, result shift register, borrow, counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == SHIFT) begin
      r_a      <= {1'b0, r_a[WIDTH-1:1]};
      r_b      <= {1'b0, r_b[WIDTH-1:1]};
      // After WIDTH shifts the first (LSB) difference bit reaches bit 0.
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_borrow <= w_bnext;
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_borrow;

`ifdef SERSUB_OVF_EN
  logic r_ovf;

  // Overflow when the operand signs differ and the result sign differs from
  // the minuend sign; captured while the MSB is in the cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == SHIFT && w_last) begin
      r_ovf <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // One full operation with out_ready held high; checks latency and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] ediff, input logic ebout, input logic eovf);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check("ready_before_op", 32'(in_ready), 1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    tick();
    in_valid = 1'b0;
    a        = '1;
    b        = '0;
    check("in_ready_shift", 32'(in_ready), 0);
    k = 0;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    check("latency", 32'(k), W);
    check("diff", 32'(diff), 32'(ediff));
    check("bout", 32'(bout), 32'(ebout));
`ifdef SERSUB_OVF_EN
    check("ovf", 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) check("ovf_arg", 0, 1);
`endif
    tick();
    check("ready_after_done", 32'(in_ready), 1);
    check("valid_after_done", 32'(out_valid), 0);
  endtask

  // Back-to-back vectors
  logic [W-1:0] bb_a    [4] = '{3'd1, 3'd6, 3'd2, 3'd5};
  logic [W-1:0] bb_b    [4] = '{3'd2, 3'd3, 3'd2, 3'd7};
  logic [W-1:0] bb_diff [4] = '{3'd7, 3'd3, 3'd0, 3'd6};
  logic         bb_bout [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int acc_cyc [4];
    int nacc;
    int nres;
    int guard;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_bout", 32'(bout), 0);
`ifdef SERSUB_OVF_EN
    check("rst_ovf", 32'(ovf), 0);
`endif

    // Directed vectors: a, b, diff, bout, signed overflow
    run_op(3'd5, 3'd3, 3'b010, 1'b0, 1'b1);
    run_op(3'd3, 3'd5, 3'b110, 1'b1, 1'b1);
    run_op(3'd0, 3'd0, 3'b000, 1'b0, 1'b0);
    run_op(3'd7, 3'd7, 3'b000, 1'b0, 1'b0);
    run_op(3'b011, 3'b100, 3'b111, 1'b1, 1'b1);
    run_op(3'b100, 3'b001, 3'b011, 1'b0, 1'b1);

    // Back-pressure: 6 - 2 = 4 held while out_ready is low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 3'd6;
    b         = 3'd2;
    tick();
    in_valid  = 1'b0;
    tick();
    tick();
    tick();
    check("bp_valid", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_diff", 32'(diff), 4);
      check("bp_hold_bout", 32'(bout), 0);
      check("bp_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(in_ready), 1);
    check("bp_release_valid", 32'(out_valid), 0);

    // Reset during the second SHIFT cycle abandons the operation
    in_valid = 1'b1;
    a        = 3'd7;
    b        = 3'd1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_diff", 32'(diff), 0);
    check("abort_bout", 32'(bout), 0);
    run_op(3'd6, 3'd1, 3'd5, 1'b0, 1'b0);

    // Back-to-back with in_valid held high; operands are junk while not ready
    nacc  = 0;
    nres  = 0;
    guard = 0;
    while (nres < 4 && guard < 60) begin
      if (out_valid) begin
        if (nres < nacc) begin
          check("b2b_diff", 32'(diff), 32'(bb_diff[nres]));
          check("b2b_bout", 32'(bout), 32'(bb_bout[nres]));
          check("b2b_latency", 32'(cyc - acc_cyc[nres]), W);
          nres++;
        end else begin
          check("b2b_spurious_result", 0, 1);
          nres = 4;
        end
      end
      if (in_ready && nacc < 4) begin
        in_valid      = 1'b1;
        a             = bb_a[nacc];
        b             = bb_b[nacc];
        acc_cyc[nacc] = cyc + 1;
        nacc++;
      end else begin
        in_valid = (nacc < 4);
        a        = 3'd0;
        b        = 3'd7;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("b2b_results", 32'(nres), 4);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), W + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
